ram_bank_dp: RTL and testbench

Parametrised true dual-port synchronous RAM bank that replaces the single-port bus RAM. It is a drop-in data/program memory for the microprocessor datapath and a DMA/loader side-channel. It adds byte-lane write enables, a configurable registered read latency, a defined collision policy and a reset-time clear sequencer with a ready indication. Each port uses separate write-data and read-data buses; there is no tri-state bus.

---
 rtl/ram_bank_dp.sv | 132 +++++++++++++
 tb/tb_ram_bank_dp.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bank_dp.sv
// ram_bank_dp: true dual-port synchronous RAM bank with byte-lane writes,
// RD_LAT-deep registered reads and an optional post-reset clear sweep.
module ram_bank_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 8,
    parameter int DEPTH          = 256,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_req,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              ready_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_acc, b_acc, a_in, b_in, a_wr, b_wr;
    logic [IDX_W-1:0]  a_idx, b_idx, clr_idx;

    logic              rd_acc  [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [RD_LAT-1:0] vin     [2];
    logic [DATA_W-1:0] din     [2][RD_LAT];
    logic [RD_LAT-1:0] vld_q   [2];
    logic [DATA_W-1:0] pipe_q  [2][RD_LAT];

    assign a_acc   = a_req & ready_q & ~reset;
    assign b_acc   = b_req & ready_q & ~reset;
    assign a_in    = int'(a_addr) < DEPTH;
    assign b_in    = int'(b_addr) < DEPTH;
    assign a_idx   = a_addr[IDX_W-1:0];
    assign b_idx   = b_addr[IDX_W-1:0];
    assign clr_idx = clr_addr_q[IDX_W-1:0];
    assign a_wr    = a_acc & a_we & a_in;
    assign b_wr    = b_acc & b_we & b_in;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == S_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET != 0) state_q <= S_CLEAR;
            else                     state_q <= S_RUN;
            clr_addr_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            ready_q    <= (state_d == S_RUN);
        end
    end

    // Port A owns any lane both ports enable at the same address; B's write
    // is masked there so the result never depends on assignment order.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_CLEAR) mem[clr_idx] <= '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (a_wr && a_be[i])
                mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
            if (b_wr && b_be[i] && !(a_wr && a_be[i] && a_idx == b_idx))
                mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
        end
    end

    always_comb begin
        rd_acc[0]  = a_acc & ~a_we;
        rd_acc[1]  = b_acc & ~b_we;
        rd_data[0] = a_in ? mem[a_idx] : '0;
        rd_data[1] = b_in ? mem[b_idx] : '0;
        for (int unsigned p = 0; p < 2; p++) begin
            vin[p][0] = rd_acc[p];
            din[p][0] = rd_data[p];
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                vin[p][s] = vld_q[p][s-1];
                din[p][s] = pipe_q[p][s-1];
            end
        end
    end

    // Inner stages shift freely; the last stage only loads on a valid beat
    // so rdata holds between reads.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                if (reset) begin
                    vld_q[p][s]  <= 1'b0;
                    pipe_q[p][s] <= '0;
                end else begin
                    vld_q[p][s] <= vin[p][s];
                    if (int'(s) != RD_LAT - 1 || vin[p][s])
                        pipe_q[p][s] <= din[p][s];
                end
            end
        end
    end

    assign ready    = ready_q;
    assign a_rdata  = pipe_q[0][RD_LAT-1];
    assign a_rvalid = vld_q[0][RD_LAT-1];
    assign b_rdata  = pipe_q[1][RD_LAT-1];
    assign b_rvalid = vld_q[1][RD_LAT-1];

endmodule

// File: tb/tb_ram_bank_dp.sv
// tb_ram_bank_dp: three differently-parameterised banks share one stimulus
// stream and are each compared every cycle against a behavioural model.
module tb_ram_bank_dp;

    localparam int NI = 3;

    function automatic int dep_of(input int i);
        case (i)
            0:       return 16;
            1:       return 200;
            default: return 32;
        endcase
    endfunction

    function automatic int lat_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int clr_of(input int i);
        return (i == 2) ? 0 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be;
    logic [7:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        ready_w   [NI];
    logic        arvalid_w [NI];
    logic        brvalid_w [NI];
    logic [31:0] ardata_w  [NI];
    logic [31:0] brdata_w  [NI];

    initial forever #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ram_bank_dp #(
            .DATA_W(32),
            .ADDR_W(8),
            .DEPTH(dep_of(g)),
            .RD_LAT(lat_of(g)),
            .CLEAR_ON_RESET(clr_of(g))
        ) u_dut (
            .clk(clk),
            .reset(reset),
            .ready(ready_w[g]),
            .a_req(a_req),
            .a_we(a_we),
            .a_be(a_be),
            .a_addr(a_addr),
            .a_wdata(a_wdata),
            .a_rdata(ardata_w[g]),
            .a_rvalid(arvalid_w[g]),
            .b_req(b_req),
            .b_we(b_we),
            .b_be(b_be),
            .b_addr(b_addr),
            .b_wdata(b_wdata),
            .b_rdata(brdata_w[g]),
            .b_rvalid(brvalid_w[g])
        );
    end

    // Model: word array per bank, and reads scheduled into a slot ring keyed
    // by the cycle in which their data must be visible.
    logic [31:0] mm      [NI][256];
    bit          m_ready [NI];
    int          m_clr   [NI];
    bit          ev      [NI][2][8];
    logic [31:0] ed      [NI][2][8];
    bit          xv      [NI][2];
    logic [31:0] xd      [NI][2];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input int i, input logic [7:0] addr);
        if (int'(addr) >= dep_of(i)) return 32'h0;
        return mm[i][addr];
    endfunction

    task automatic wr_model(input int i, input logic [3:0] be, input logic [7:0] addr,
                            input logic [31:0] d);
        if (int'(addr) >= dep_of(i)) return;
        for (int k = 0; k < 4; k++)
            if (be[k]) mm[i][addr][8*k +: 8] = d[8*k +: 8];
    endtask

    task automatic model_edge();
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_ready[i] = 1'b0;
                m_clr[i]   = 0;
                for (int p = 0; p < 2; p++) begin
                    xv[i][p] = 1'b0;
                    xd[i][p] = 32'h0;
                    for (int s = 0; s < 8; s++) ev[i][p][s] = 1'b0;
                end
                continue;
            end
            if (m_ready[i]) begin
                int due;
                due = (cyc + lat_of(i) - 1) % 8;
                if (a_req && !a_we) begin
                    ev[i][0][due] = 1'b1;
                    ed[i][0][due] = rd_model(i, a_addr);
                end
                if (b_req && !b_we) begin
                    ev[i][1][due] = 1'b1;
                    ed[i][1][due] = rd_model(i, b_addr);
                end
                if (b_req && b_we) wr_model(i, b_be, b_addr, b_wdata);
                if (a_req && a_we) wr_model(i, a_be, a_addr, a_wdata);
            end else if (clr_of(i) == 0) begin
                m_ready[i] = 1'b1;
            end else begin
                m_clr[i]++;
                if (m_clr[i] == dep_of(i)) begin
                    m_ready[i] = 1'b1;
                    for (int w = 0; w < dep_of(i); w++) mm[i][w] = 32'h0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                int slot;
                slot     = cyc % 8;
                xv[i][p] = ev[i][p][slot];
                if (ev[i][p][slot]) begin
                    xd[i][p]       = ed[i][p][slot];
                    ev[i][p][slot] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("u%0d.ready c%0d", i, cyc), 32'(ready_w[i]), 32'(m_ready[i]));
            check($sformatf("u%0d.a_rvalid c%0d", i, cyc), 32'(arvalid_w[i]), 32'(xv[i][0]));
            check($sformatf("u%0d.a_rdata c%0d", i, cyc), ardata_w[i], xd[i][0]);
            check($sformatf("u%0d.b_rvalid c%0d", i, cyc), 32'(brvalid_w[i]), 32'(xv[i][1]));
            check($sformatf("u%0d.b_rdata c%0d", i, cyc), brdata_w[i], xd[i][1]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_be = '0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_be = '0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic drv_a(input bit req, input bit we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] d);
        a_req = req; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
    endtask

    task automatic drv_b(input bit req, input bit we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] d);
        b_req = req; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
    endtask

    function automatic logic [7:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(190, 255));
        return 8'($urandom_range(0, 39));
    endfunction

    task automatic rand_stim();
        drv_a($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), pick_addr(), $urandom);
        drv_b($urandom_range(0, 9) < 7, 1'($urandom), 4'($urandom), pick_addr(), $urandom);
        if ($urandom_range(0, 2) == 0) b_addr = a_addr;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
        run(205);

        // Fill every bank with ones so the later clear is observable.
        for (int k = 0; k < 256; k++) begin
            drv_a(1'b1, 1'b1, 4'hF, 8'(k), 32'hFFFF_FFFF);
            step();
        end
        idle();
        run(2);

        reset = 1'b1;
        run(2);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            drv_a(1'b1, k[0], 4'hF, 8'(k), 32'h5A5A_0000 | 32'(k));
            drv_b(1'b1, !k[0], 4'hF, 8'(k + 1), 32'hC3C3_0000 | 32'(k));
            step();
        end
        idle();
        run(200);

        for (int k = 0; k < 16; k++) begin
            drv_a(1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
            step();
        end
        idle();
        run(6);

        drv_a(1'b1, 1'b1, 4'hF, 8'd5, 32'h1122_3344);
        step();
        drv_a(1'b1, 1'b1, 4'b0101, 8'd5, 32'hAABB_CCDD);
        step();
        drv_a(1'b1, 1'b0, 4'h0, 8'd5, 32'h0);
        step();
        idle();
        run(5);

        for (int k = 1; k <= 3; k++) begin
            drv_a(1'b1, 1'b1, 4'hF, 8'(k), 32'h9 + 32'(k));
            step();
        end
        for (int k = 1; k <= 3; k++) begin
            drv_a(1'b1, 1'b0, 4'h0, 8'(k), 32'h0);
            step();
        end
        idle();
        run(6);

        drv_a(1'b1, 1'b1, 4'b0001, 8'd7, 32'h0000_00AA);
        drv_b(1'b1, 1'b1, 4'b0011, 8'd7, 32'h0000_BBBB);
        step();
        drv_a(1'b1, 1'b0, 4'h0, 8'd7, 32'h0);
        drv_b(1'b1, 1'b1, 4'hF, 8'd7, 32'h1234_5678);
        step();
        idle();
        drv_a(1'b1, 1'b0, 4'h0, 8'd7, 32'h0);
        drv_b(1'b1, 1'b0, 4'h0, 8'd7, 32'h0);
        step();
        idle();
        run(5);

        drv_a(1'b1, 1'b1, 4'hF, 8'd250, 32'hDEAD_BEEF);
        drv_b(1'b1, 1'b1, 4'hF, 8'd199, 32'h0BAD_F00D);
        step();
        drv_a(1'b1, 1'b0, 4'h0, 8'd250, 32'h0);
        drv_b(1'b1, 1'b0, 4'h0, 8'd199, 32'h0);
        step();
        idle();
        run(5);

        repeat (1500) begin
            rand_stim();
            step();
        end

        idle();
        drv_a(1'b1, 1'b0, 4'h0, 8'd3, 32'h0);
        step();
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        run(205);

        repeat (400) begin
            rand_stim();
            step();
        end
        idle();
        run(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
